// File: rtl/loader_pkg.sv
// Shared loader definitions: memory geometry and loader state encoding.
// The CPU instruction-memory module imports the same package.
package loader_pkg;

    localparam int unsigned DEPTH = 128;
    localparam int unsigned AW    = 7;
    localparam int unsigned ST_W  = 3;

    localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_W-1:0] ST_LEN_LO = 3'd1;
    localparam logic [ST_W-1:0] ST_LEN_HI = 3'd2;
    localparam logic [ST_W-1:0] ST_DATA   = 3'd3;
    localparam logic [ST_W-1:0] ST_WRITE  = 3'd4;
    localparam logic [ST_W-1:0] ST_DONE   = 3'd5;
    localparam logic [ST_W-1:0] ST_ERR    = 3'd6;

    typedef enum logic [ST_W-1:0] {
        IDLE   = ST_IDLE,
        LEN_LO = ST_LEN_LO,
        LEN_HI = ST_LEN_HI,
        DATA   = ST_DATA,
        WRITE  = ST_WRITE,
        DONE   = ST_DONE,
        ERR    = ST_ERR
    } state_t;

    // States in which the loader takes bytes from the stream.
    function automatic logic accepts(input state_t s);
        return (s == LEN_LO) || (s == LEN_HI) || (s == DATA);
    endfunction

endpackage

// File: rtl/ins_loader.sv
// Byte-stream instruction loader: reads a 16-bit word count and 4N bytes,
// writes little-endian words into instruction memory, then releases the CPU.
module ins_loader #(
    parameter int unsigned DEPTH = loader_pkg::DEPTH,
    parameter int unsigned AW    = loader_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          ins_we,
    output logic [AW-1:0] ins_addr,
    output logic [31:0]   ins_wdata,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);
    import loader_pkg::*;

    localparam int unsigned LW = 16;

    state_t          state_q, state_d;
    logic [LW-1:0]   len_q, len_d;
    logic [AW-1:0]   widx_q, widx_d;
    logic [1:0]      bcnt_q, bcnt_d;
    logic [31:0]     asm_q, asm_d;
    logic [AW-1:0]   addr_d;
    logic [31:0]     wdata_d;
    logic            we_d;
    logic            ready_d;
    logic            cpu_rst_d;
    logic            done_d;
    logic            err_d;
    logic            xfer;

    assign xfer = in_valid & in_ready;

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            widx_q    <= '0;
            bcnt_q    <= '0;
            asm_q     <= '0;
            in_ready  <= 1'b0;
            ins_we    <= 1'b0;
            ins_addr  <= '0;
            ins_wdata <= '0;
            cpu_rst   <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            widx_q    <= widx_d;
            bcnt_q    <= bcnt_d;
            asm_q     <= asm_d;
            in_ready  <= ready_d;
            ins_we    <= we_d;
            ins_addr  <= addr_d;
            ins_wdata <= wdata_d;
            cpu_rst   <= cpu_rst_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

    // Next state, counters and next-cycle outputs.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        widx_d  = widx_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        addr_d  = ins_addr;
        wdata_d = ins_wdata;
        we_d    = 1'b0;

        // Start wins over everything, including a byte offered in the same cycle.
        if (start) begin
            state_d = LEN_LO;
            len_d   = '0;
            widx_d  = '0;
            bcnt_d  = '0;
            asm_d   = '0;
        end else begin
            case (state_q)
                IDLE: ;
                LEN_LO: begin
                    if (xfer) begin
                        len_d   = {8'h00, in_data};
                        state_d = LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_d  = {in_data, len_q[7:0]};
                        widx_d = '0;
                        bcnt_d = '0;
                        if ((len_d == '0) || (len_d > LW'(DEPTH))) begin
                            state_d = ERR;
                        end else begin
                            state_d = DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        // First byte lands in bits [7:0] after four right shifts.
                        asm_d = {in_data, asm_q[31:8]};
                        if (bcnt_q == 2'd3) begin
                            bcnt_d  = '0;
                            state_d = WRITE;
                            we_d    = 1'b1;
                            addr_d  = widx_q;
                            wdata_d = asm_d;
                        end else begin
                            bcnt_d = bcnt_q + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (widx_q == AW'(len_q - LW'(1))) begin
                        state_d = DONE;
                    end else begin
                        widx_d  = widx_q + AW'(1);
                        state_d = DATA;
                    end
                end
                DONE: ;
                ERR: ;
                default: state_d = IDLE;
            endcase
        end

        ready_d   = accepts(state_d);
        cpu_rst_d = (state_d != DONE);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

endmodule

// File: tb/tb_ins_loader.sv
// Directed bench for ins_loader: expected writes go into a scoreboard queue
// as words are driven and are popped when the loader strobes ins_we.
module tb_ins_loader;

    localparam int unsigned AW = 7;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          ins_we;
    logic [AW-1:0] ins_addr;
    logic [31:0]   ins_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    logic [AW-1:0] last_addr = '0;
    wr_t sb[$];

    ins_loader #(.DEPTH(128), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ins_we    (ins_we),
        .ins_addr  (ins_addr),
        .ins_wdata (ins_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (ins_we) begin
            wr_t e;
            wr_cnt++;
            last_addr = ins_addr;
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL extra_we observed addr=%h data=%h expected no write", ins_addr, ins_wdata);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                assert ({ins_addr, ins_wdata} === {e.addr, e.data}) else begin
                    failures++;
                    $error("FAIL wr observed addr=%h data=%h expected addr=%h data=%h",
                           ins_addr, ins_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("byte_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_len(input logic [15:0] n);
        send_byte(n[7:0]);
        send_byte(n[15:8]);
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [31:0] w);
        wr_t e;
        e.addr = a;
        e.data = w;
        sb.push_back(e);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!done && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("done", 32'(done), 32'd1);
        chk("cpu_rst_done", 32'(cpu_rst), 32'd0);
        chk("err_done", 32'(err), 32'd0);
    endtask

    initial begin
        int base;
        logic [31:0] w [3];

        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_ins_we",   32'(ins_we),   32'd0);
        chk("rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_err",      32'(err),      32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Single-word load.
        base = wr_cnt;
        pulse_start();
        chk("ready_len_lo", 32'(in_ready), 32'd1);
        send_len(16'd1);
        chk("cpu_rst_loading", 32'(cpu_rst), 32'd1);
        send_word(7'd0, 32'h0050_0513);
        wait_done();
        chk("single_wr_cnt", 32'(wr_cnt - base), 32'd1);
        chk("ready_done", 32'(in_ready), 32'd0);

        // Three words with a 5-cycle stall mid-word.
        base = wr_cnt;
        w[0] = 32'hDEAD_BEEF;
        w[1] = 32'h1234_5678;
        w[2] = 32'hA5A5_0F0F;
        pulse_start();
        chk("done_cleared", 32'(done), 32'd0);
        send_len(16'd3);
        send_word(7'd0, w[0]);
        begin
            wr_t e;
            e.addr = 7'd1;
            e.data = w[1];
            sb.push_back(e);
        end
        send_byte(w[1][7:0]);
        send_byte(w[1][15:8]);
        repeat (5) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        chk("stall_ready", 32'(in_ready), 32'd1);
        send_byte(w[1][23:16]);
        send_byte(w[1][31:24]);
        send_word(7'd2, w[2]);
        wait_done();
        chk("three_wr_cnt", 32'(wr_cnt - base), 32'd3);

        // Rejected counts: N=0 and N=129.
        base = wr_cnt;
        pulse_start();
        send_len(16'd0);
        chk("n0_err",      32'(err),      32'd1);
        chk("n0_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("n0_in_ready", 32'(in_ready), 32'd0);
        chk("n0_done",     32'(done),     32'd0);
        pulse_start();
        chk("err_cleared", 32'(err), 32'd0);
        send_byte(8'h81);
        send_byte(8'h00);
        repeat (3) @(negedge clk);
        chk("n129_err",      32'(err),      32'd1);
        chk("n129_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("n129_in_ready", 32'(in_ready), 32'd0);
        chk("err_wr_cnt", 32'(wr_cnt - base), 32'd0);

        // Full-depth load.
        base = wr_cnt;
        pulse_start();
        send_len(16'd128);
        for (int i = 0; i < 128; i++) send_word(AW'(i), $urandom);
        wait_done();
        chk("full_wr_cnt", 32'(wr_cnt - base), 32'd128);
        chk("full_last_addr", 32'(last_addr), 32'h7F);

        // Restart after 2 of 3 words, with a byte offered alongside start.
        base = wr_cnt;
        pulse_start();
        send_len(16'd3);
        send_word(7'd0, 32'h0101_0101);
        send_word(7'd1, 32'h0202_0202);
        in_valid = 1'b1;
        in_data  = 8'h05;
        pulse_start();
        in_valid = 1'b0;
        send_len(16'd1);
        send_word(7'd0, 32'hCAFE_F00D);
        wait_done();
        chk("restart_wr_cnt", 32'(wr_cnt - base), 32'd3);

        // Reset in the middle of DATA.
        base = wr_cnt;
        pulse_start();
        send_len(16'd2);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_ins_we",   32'(ins_we),   32'd0);
        chk("mid_rst_cpu_rst",  32'(cpu_rst),  32'd1);
        chk("mid_rst_done",     32'(done),     32'd0);
        chk("mid_rst_err",      32'(err),      32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("mid_rst_idle_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_wr_cnt", 32'(wr_cnt - base), 32'd0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ins_loader.md
INS_LOADER -- requirements
Module: ins_loader

Interface
REQ-001 SHALL have parameter DEPTH, 128, instruction-memory depth in 32-bit words.
REQ-002 SHALL have parameter AW, 7, word-address width, equal to log2(DEPTH); it matches pc[8:2].
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a load.
REQ-006 SHALL have port in_data  input  8  incoming byte.
REQ-007 SHALL have port in_valid  input  1  in_data is valid.
REQ-008 SHALL have port in_ready  output  1  loader accepts a byte; transfer = in_valid & in_ready.
REQ-009 SHALL have port ins_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port ins_addr  output  AW  word address for the write.
REQ-011 SHALL have port ins_wdata  output  32  instruction word for the write.
REQ-012 SHALL have port cpu_rst  output  1  active-high reset driven to the CPU core.
REQ-013 SHALL have port done  output  1  load completed successfully (level).
REQ-014 SHALL have port err  output  1  load rejected (level).

Function
REQ-015 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR.
REQ-016 SHALL accept the stream format: 16-bit word count N, low byte first, then 4N bytes; each word is little-endian, first byte = bits[7:0].
REQ-017 SHALL assert in_ready only in LEN_LO, LEN_HI and DATA.
REQ-018 SHALL move IDLE->LEN_LO on start; LEN_LO->LEN_HI and LEN_HI->check on each transfer.
REQ-019 SHALL go to ERR on N==0 or N>DEPTH, with no memory writes; otherwise it SHALL go to DATA with word index 0.
REQ-020 SHALL, in DATA, shift each accepted byte into a 32-bit assembly register and count bytes 0..3; the 4th byte moves the block to WRITE.
REQ-021 SHALL, in WRITE, assert ins_we for exactly one cycle with ins_addr = word index and ins_wdata = the assembled word; write latency is 1 cycle after the 4th byte.
REQ-022 SHALL, after WRITE, increment the word index and return to DATA, or go to DONE when index == N-1.
REQ-023 SHALL keep cpu_rst=1 in every state except DONE; in DONE cpu_rst=0 and done=1.
REQ-024 SHALL hold err=1 and cpu_rst=1 in ERR until the next start.
REQ-025 SHALL treat start in any state as a restart: go to LEN_LO, clear done, err, byte count and word index, and drive cpu_rst=1 from the next cycle. A byte transferred in the same cycle as start SHALL be discarded.
REQ-026 SHALL leave stalls unbounded: in_valid low in any accepting state holds state and counters.
REQ-027 SHALL drive ins_we=0 in every state except WRITE; ins_addr/ins_wdata are don't-care when ins_we=0.

Reset
REQ-028 SHALL, when rst=0 at a clock edge, enter IDLE with in_ready=0, ins_we=0, cpu_rst=1, done=0, err=0, counters 0 and assembly register 0.
REQ-029 SHALL abandon a load when reset arrives mid-load; words already written remain in memory.

Structure
REQ-030 SHALL take the state encoding localparams and the DEPTH/AW defaults from a shared package, loader_pkg, which the CPU's instruction-memory module also uses.
REQ-031 SHALL be a single module with no sub-modules; byte assembly is a shift register inside it.

Verification
REQ-032 SHALL cover a single-word load. Stimulus: start; bytes 01 00 13 05 50 00. Required response: one ins_we with addr 0 and data 00500513; then done=1, cpu_rst=0.
REQ-033 SHALL cover a 3-word load with in_valid low for 5 cycles mid-word. Required response: writes to addr 0,1,2 in order; no extra ins_we; the stall changes no data.
REQ-034 SHALL cover the error counts. Stimulus: N=0 and N=129 (bytes 81 00). Required response: err=1, cpu_rst=1, zero writes, in_ready=0.
REQ-035 SHALL cover a full load of N=128. Required response: the last write goes to addr 127 (7'h7F) with no address wrap; done=1.
REQ-036 SHALL cover a restart. Stimulus: start pulse after 2 of 3 words, then a new N=1 stream. Required response: the new word is written at addr 0, done=1, and err is clear.
REQ-037 SHALL cover reset mid-load. Stimulus: rst=0 for one cycle during DATA. Required response: the IDLE outputs of REQ-028 on the next cycle, and no ins_we until the next start.
